machine_timer: RTL

Memory-mapped RISC-V machine timer and software-interrupt source. Keeps the 64-bit `mtime` counter, the 64-bit `mtimecmp` compare register and the `msip` bit. It drives the `irq_timer` and `irq_software` inputs of the machine-mode CSR block, so it sits directly upstream of the CSR file. The CPU reaches it through the data-bus decoder as a small peripheral.

---
 rtl/mtimer_pkg.sv | 12 +
 rtl/mtimer_prescaler.sv | 27 ++
 rtl/machine_timer.sv | 99 +++++++++
 3 files changed

// File: rtl/mtimer_pkg.sv
// Shared register offsets and reset constants for the RISC-V machine timer.
package mtimer_pkg;

  localparam logic [4:0]  MTIME_LO     = 5'h00;
  localparam logic [4:0]  MTIME_HI     = 5'h04;
  localparam logic [4:0]  MTIMECMP_LO  = 5'h08;
  localparam logic [4:0]  MTIMECMP_HI  = 5'h0C;
  localparam logic [4:0]  MSIP         = 5'h10;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/mtimer_prescaler.sv
// Free-running divider: tick is high on the cycle the count holds CLK_DIV-1.
module mtimer_prescaler #(
  parameter int CLK_DIV = 1
) (
  input  logic clock,
  input  logic reset_L,
  output logic tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_count;

  assign tick = (r_count == LAST);

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_count <= '0;
    end else if (tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/machine_timer.sv
// Memory-mapped mtime/mtimecmp/msip block driving the CSR timer and software IRQs.
// Optional MTIMER_SNAPSHOT_EN: reading mtime_lo latches mtime_hi into a shadow for a coherent 64-bit read.
module machine_timer
  import mtimer_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic        clock,
  input  logic        reset_L,
  input  logic        CS_L,
  input  logic        WE_L,
  input  logic [4:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        irq_timer,
  output logic        irq_software
);

  logic        w_tick;
  logic        w_wr;
  logic        w_rd;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic        r_irq_timer;

  assign w_wr = !CS_L && !WE_L;
  assign w_rd = !CS_L &&  WE_L;

  mtimer_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clock   (clock),
    .reset_L (reset_L),
    .tick    (w_tick)
  );

  // A write to either mtime half suppresses the increment (and its carry) for that cycle.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_mtime <= '0;
    end else if (w_wr && address == MTIME_LO) begin
      r_mtime[31:0] <= write_data;
    end else if (w_wr && address == MTIME_HI) begin
      r_mtime[63:32] <= write_data;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_mtimecmp  <= MTIMECMP_RST;
      r_msip      <= 1'b0;
      r_irq_timer <= 1'b0;
    end else begin
      r_irq_timer <= (r_mtime >= r_mtimecmp);
      if (w_wr && address == MTIMECMP_LO) r_mtimecmp[31:0]  <= write_data;
      if (w_wr && address == MTIMECMP_HI) r_mtimecmp[63:32] <= write_data;
      if (w_wr && address == MSIP)        r_msip            <= write_data[0];
    end
  end

  assign irq_timer    = r_irq_timer;
  assign irq_software = r_msip;

`ifdef MTIMER_SNAPSHOT_EN
  logic [31:0] r_shadow;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_shadow <= '0;
    end else if (w_rd && address == MTIME_LO) begin
      r_shadow <= r_mtime[63:32];
    end else if (w_wr && address == MTIME_HI) begin
      r_shadow <= write_data;
    end
  end
`endif

  always_comb begin
    read_data = '0;
    if (w_rd) begin
      case (address)
        MTIME_LO:    read_data = r_mtime[31:0];
`ifdef MTIMER_SNAPSHOT_EN
        MTIME_HI:    read_data = r_shadow;
`else
        MTIME_HI:    read_data = r_mtime[63:32];
`endif
        MTIMECMP_LO: read_data = r_mtimecmp[31:0];
        MTIMECMP_HI: read_data = r_mtimecmp[63:32];
        MSIP:        read_data = {31'd0, r_msip};
        default:     read_data = '0;
      endcase
    end
  end

endmodule
